// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and types for the register bank.
//   REG_WIDTH  - default register/data width
//   REG_DEPTH  - default number of registers
//   PC_INDEX   - default program-counter register index
//   PC_INCR    - default PC auto-increment step
//   reg_word_t - one register word at the default width
package reg_file_pkg;

  localparam int REG_WIDTH = 32;
  localparam int REG_DEPTH = 16;
  localparam int PC_INDEX  = 15;
  localparam int PC_INCR   = 4;

  typedef logic [REG_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/reg_cell.sv
// reg_cell: one WIDTH-bit storage register.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low clear
//   load  - capture d on the next rising edge
//   d     - data input
//   q     - stored value
module reg_cell
  import reg_file_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage flop: cleared asynchronously, holds unless loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= {WIDTH{1'b0}};
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/reg_file_bank.sv
// reg_file_bank: DEPTH x WIDTH register bank, two combinational read ports,
// one synchronous write port, and an auto-incrementing program counter.
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle write
// data to a read port whose address matches the write address.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low clear of all registers
//   we, wa, wd   - write enable, write address, write data
//   ra_a, ra_b   - read addresses
//   pc_inc       - advance the PC register by PC_STEP
//   rd_a, rd_b   - read data (combinational)
//   pc_out       - stored PC register value
module reg_file_bank
  import reg_file_pkg::*;
#(
  parameter  int WIDTH   = REG_WIDTH,
  parameter  int DEPTH   = REG_DEPTH,
  localparam int AW      = $clog2(DEPTH),
  parameter  int PC_IDX  = PC_INDEX,
  parameter  int PC_STEP = PC_INCR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra_a,
  input  logic [AW-1:0]    ra_b,
  input  logic             pc_inc,
  output logic [WIDTH-1:0] rd_a,
  output logic [WIDTH-1:0] rd_b,
  output logic [WIDTH-1:0] pc_out
);

  // With a power-of-two depth every address decodes to a register, so the
  // range check would be constant; only build it when it matters.
  localparam bit FULL_DECODE = (DEPTH == (1 << AW));

  logic [WIDTH-1:0] q      [DEPTH];
  logic [WIDTH-1:0] cell_d [DEPTH];
  logic [DEPTH-1:0] cell_load;
  logic [WIDTH-1:0] pc_next;
  logic             valid_a;
  logic             valid_b;
  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;

  // Truncating add gives the required wrap of the PC.
  assign pc_next = q[PC_IDX] + WIDTH'(PC_STEP);
  assign pc_out  = q[PC_IDX];

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic wr_hit;
    assign wr_hit = we && (wa == AW'(i));

    if (i == PC_IDX) begin : g_pc
      // Write beats increment (branch semantics).
      assign cell_load[i] = wr_hit | pc_inc;
      assign cell_d[i]    = wr_hit ? wd : pc_next;
    end else begin : g_gp
      assign cell_load[i] = wr_hit;
      assign cell_d[i]    = wd;
    end

    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cell_load[i]),
      .d     (cell_d[i]),
      .q     (q[i])
    );
  end

  if (FULL_DECODE) begin : g_full
    assign valid_a = 1'b1;
    assign valid_b = 1'b1;
  end else begin : g_part
    assign valid_a = (int'(ra_a) < DEPTH);
    assign valid_b = (int'(ra_b) < DEPTH);
  end

  // Stored-value read mux; unmapped addresses read zero.
  always_comb begin
    stored_a = {WIDTH{1'b0}};
    stored_b = {WIDTH{1'b0}};
    if (valid_a) begin
      stored_a = q[ra_a];
    end else begin
      stored_a = {WIDTH{1'b0}};
    end
    if (valid_b) begin
      stored_b = q[ra_b];
    end else begin
      stored_b = {WIDTH{1'b0}};
    end
  end

  // Output selection, optionally forwarding the in-flight write data.
  // Forwarding is suppressed during reset so reads stay zero.
  always_comb begin
    rd_a = stored_a;
    rd_b = stored_b;
`ifdef REG_FILE_BYPASS_EN
    if (rst_n && we && valid_a && (wa == ra_a)) begin
      rd_a = wd;
    end else begin
      rd_a = stored_a;
    end
    if (rst_n && we && valid_b && (wa == ra_b)) begin
      rd_b = wd;
    end else begin
      rd_b = stored_b;
    end
`else
    rd_a = stored_a;
    rd_b = stored_b;
`endif
  end

endmodule

// File: tb/tb_reg_file_bank.sv
// tb_reg_file_bank: directed and randomized self-checking bench for
// reg_file_bank at default parameters (16 x 32, PC = R15, step 4).
// Expected values come from a word-array model of the register file.
module tb_reg_file_bank;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic [3:0]  ra_a;
  logic [3:0]  ra_b;
  logic        pc_inc;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic [31:0] pc_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [16];

  reg_file_bank dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .wa     (wa),
    .wd     (wd),
    .ra_a   (ra_a),
    .ra_b   (ra_b),
    .pc_inc (pc_inc),
    .rd_a   (rd_a),
    .rd_b   (rd_b),
    .pc_out (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value a read port should show before the edge, given the current inputs.
  function automatic logic [31:0] exp_read(input logic [3:0] addr);
`ifdef REG_FILE_BYPASS_EN
    if (we && (wa == addr)) return wd;
`endif
    return mdl[addr];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic inc, input logic [3:0] xa, input logic [3:0] xb);
    logic [31:0] pc_new;
    we = w; wa = a; wd = d; pc_inc = inc; ra_a = xa; ra_b = xb;
    #1;
    check("rd_a_pre", rd_a, exp_read(xa));
    check("rd_b_pre", rd_b, exp_read(xb));
    check("pc_pre", pc_out, mdl[15]);
    @(posedge clk);
    pc_new = inc ? mdl[15] + 32'd4 : mdl[15];
    mdl[15] = pc_new;
    if (w) mdl[a] = d;
    #1;
    check("pc_post", pc_out, mdl[15]);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; wa = 4'd0; wd = 32'h0;
    ra_a = 4'd0; ra_b = 4'd0; pc_inc = 1'b0;
    model_clear();

    // Reset held: all addresses read zero on both ports.
    #12;
    for (int i = 0; i < 16; i++) begin
      ra_a = 4'(i); ra_b = 4'(15 - i);
      #1;
      check("rst_rd_a", rd_a, 32'h0);
      check("rst_rd_b", rd_b, 32'h0);
    end
    check("rst_pc", pc_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write / read R3 and R7.
    cycle(1'b1, 4'd3, 32'hF0F0F0F0, 1'b0, 4'd3, 4'd7);
    cycle(1'b1, 4'd7, 32'hF0F0F0FF, 1'b0, 4'd3, 4'd7);
    cycle(1'b0, 4'd0, 32'h0, 1'b0, 4'd3, 4'd7);
    check("r3_value", rd_a, 32'hF0F0F0F0);
    check("r7_value", rd_b, 32'hF0F0F0FF);

    // PC stepping from reset.
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 4'd3);
      check("pc_step", pc_out, 32'(4 * i));
    end

    // PC wrap from all-ones-aligned value.
    cycle(1'b1, 4'd15, 32'hFFFFFFFC, 1'b0, 4'd15, 4'd15);
    check("pc_load", pc_out, 32'hFFFFFFFC);
    cycle(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 4'd15);
    check("pc_wrap", pc_out, 32'h00000000);
    cycle(1'b1, 4'd15, 32'hFFFFFFFF, 1'b0, 4'd1, 4'd2);
    cycle(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 4'd1);
    check("pc_wrap_ones", pc_out, 32'h00000003);

    // Write/increment collision: write wins.
    cycle(1'b1, 4'd15, 32'h00000100, 1'b0, 4'd15, 4'd0);
    cycle(1'b1, 4'd15, 32'h00002000, 1'b1, 4'd15, 4'd15);
    check("collision", pc_out, 32'h00002000);

    // Same-cycle write to R5 read on port A.
    cycle(1'b1, 4'd5, 32'h11112222, 1'b0, 4'd0, 4'd0);
    cycle(1'b1, 4'd5, 32'hABCD1234, 1'b0, 4'd5, 4'd5);
    cycle(1'b0, 4'd0, 32'h0, 1'b0, 4'd5, 4'd15);
    check("r5_after", rd_a, 32'hABCD1234);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      cycle(1'($urandom_range(0, 1)), a, $urandom(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
    end

    // Asynchronous reset between edges; concurrent write is lost.
    cycle(1'b1, 4'd2, 32'h5A5A5A5A, 1'b1, 4'd2, 4'd15);
    we = 1'b1; wa = 4'd2; wd = 32'hDEADBEEF; pc_inc = 1'b1; ra_a = 4'd2; ra_b = 4'd15;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rd_a", rd_a, 32'h0);
    check("arst_rd_b", rd_b, 32'h0);
    check("arst_pc", pc_out, 32'h0);
    @(posedge clk);
    #1;
    check("arst_hold_rd_a", rd_a, 32'h0);
    @(negedge clk);
    we = 1'b0; pc_inc = 1'b0;
    rst_n = 1'b1;
    model_clear();
    cycle(1'b0, 4'd0, 32'h0, 1'b0, 4'd2, 4'd3);
    check("arst_r2_lost", rd_a, 32'h0);
    check("arst_r3_clear", rd_b, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_bank.md
# reg_file_bank

Parametrised general-purpose register bank for the ARM datapath. It holds DEPTH registers of WIDTH bits with two combinational read ports and one synchronous write port. One register, the program counter, can also auto-increment. It replaces single loadable 32-bit registers as the storage element feeding the ALU operand buses and the fetch stage.

## Interface
- WIDTH, 32: bit width of every register and data port.
- DEPTH, 16: number of registers (2..256).
- AW, $clog2(DEPTH): address width (derived; not overridden).
- PC_IDX, 15: index of the program-counter register (< DEPTH).
- PC_STEP, 4: increment applied to the PC on pc_inc.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable.
- wa  input  AW  write address.
- wd  input  WIDTH  write data.
- ra_a  input  AW  read address, port A.
- ra_b  input  AW  read address, port B.
- pc_inc  input  1  advance the PC by PC_STEP this cycle.
- rd_a  output  WIDTH  read data, port A (combinational).
- rd_b  output  WIDTH  read data, port B (combinational).
- pc_out  output  WIDTH  current PC register contents (registered value).

## Operation
- Reset: rst_n low clears every register to 0 immediately, independent of clk. rd_a, rd_b and pc_out read 0 while reset is held. The first capture happens on the first rising clk after rst_n deasserts.
- Write: on rising clk with we=1 and wa < DEPTH, reg[wa] takes wd.
- PC increment: on rising clk with pc_inc=1, reg[PC_IDX] takes reg[PC_IDX] + PC_STEP, truncated to WIDTH bits. The all-ones value wraps to PC_STEP-1.
- Collision: if we=1, wa=PC_IDX and pc_inc=1 in the same cycle, the write wins and the increment is dropped (branch semantics).
- Reads: rd_x = reg[ra_x], updated combinationally. Both ports may address the same register, including PC_IDX.
- Out-of-range addresses (only when DEPTH is not a power of two):
  - writes are ignored;
  - reads return 0.
- Idle: we=0 and pc_inc=0 leave every register unchanged.

## Timing
- Write latency is 1 cycle. Without bypass, the written value is visible on rd_x and pc_out after the capturing edge.
- Read latency is 0 cycles (combinational path from ra_x to rd_x).
- pc_out always shows the stored PC. It is never bypassed.
- Reset assertion mid-cycle overrides any pending write or increment.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - when we=1 and wa==ra_x (in range), rd_x returns wd in the same cycle (write-to-read forwarding);
  - forwarding also applies when wa==PC_IDX;
  - a pc_inc-only update is not forwarded.
- Not defined: rd_x always returns the stored value, so a same-cycle write appears one cycle later.

## Structure
- Package reg_file_pkg holds:
  - defaults REG_WIDTH=32, REG_DEPTH=16, PC_INDEX=15, PC_INCR=4;
  - typedef reg_word_t (logic [REG_WIDTH-1:0]).
- Sub-module reg_cell: one WIDTH-bit register with async active-low clear, load enable, and a data input. It is instantiated DEPTH times by a generate loop. The PC cell's data/load inputs are driven by the write/increment priority mux in the top level.

## Test plan
- Reset then read: hold rst_n=0, then release; read all addresses on both ports -> all 0, pc_out=0.
- Write/read: write 0xF0F0F0F0 to R3 and 0xF0F0F0FF to R7, then ra_a=3, ra_b=7 -> rd_a=0xF0F0F0F0, rd_b=0xF0F0F0FF the cycle after each write. Before that, old values are read (or the new value with REG_FILE_BYPASS_EN).
- PC stepping: from reset, pc_inc=1 for 5 cycles -> pc_out 4, 8, 12, 16, 20. Then write 0xFFFFFFFC to R15 and assert pc_inc -> pc_out wraps to 0x00000000.
- Collision: PC=0x100; in one cycle we=1, wa=15, wd=0x2000, pc_inc=1 -> PC=0x2000 (not 0x104).
- Async reset mid-run: registers loaded; drop rst_n between clock edges -> all outputs read 0 before the next edge; a concurrent we=1 write is lost.
- Bypass: with REG_FILE_BYPASS_EN, we=1, wa=5, wd=0xABCD1234, ra_a=5 -> rd_a=0xABCD1234 in the same cycle. Without the macro, rd_a shows the old R5 until the edge.
